lfsr_checker: RTL and testbench
===============================

# lfsr_checker

- Receive-side checker for the 8-bit PRBS produced by the team's LFSR generator.
- Consumes one word per `valid` strobe and self-synchronises by seeding its predictor from the incoming stream.
- Declares lock after a run of correct predictions, then flywheels its own sequence and flags and counts every mismatching word.
- Sits at the far end of any link or datapath driven by the generator, giving bit-exact pass/fail for loopback and stream-integrity tests.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive correct predictions after the seed word required to lock (≥1).
- `UNLOCK_ERRS`, default 3: consecutive mismatches while locked that drop lock (≥1).
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` input, 1: rising-edge clock. This is the only clock.
- `rst_n` input, 1: synchronous, active-low reset.
- `valid` input, 1: `d` carries a sequence word this cycle.
- `d` input, 8: received word. It equals the generator's `q` at each generator enable.
- `clr` input, 1: synchronous clear of the statistics counters only.
- `locked` output, 1: checker is in the LOCKED state.
- `err_pulse` output, 1: one-cycle flag for a mismatching word while locked.
- `err_count` output, CNT_W: saturating count of mismatches while locked.
- `word_count` output, CNT_W: saturating count of words checked while locked.

## Operation
- Sequence function: next(x) = {x[7]^x[6]^x[5]^x[0], x[7:1]}. It matches the generator, whose reset seed is 8'h01.
- State register `pred` (8 b) holds the predicted next word.
- Counter `match_cnt` holds the verify progress.
- Counter `bad_cnt` holds the run of consecutive mismatches.
- All state updates occur only on cycles with `valid`=1. With `valid`=0, all state holds and `err_pulse`=0.
- HUNT:
  - On `valid` with `d`≠0: set `pred`←next(d), `match_cnt`←0, go to VERIFY.
  - On `d`=0, stay in HUNT. 8'h00 is the LFSR lock-up value and is never a legal seed.
- VERIFY:
  - On `d`==`pred`: `pred`←next(d), `match_cnt`+1. When the count reaches LOCK_CNT, go to LOCKED with `bad_cnt`←0.
  - On `d`≠`pred`: reseed with `pred`←next(d) and `match_cnt`←0. If `d`=0, go to HUNT instead.
  - No errors are counted in VERIFY.
- LOCKED:
  - On every `valid`, `pred`←next(pred). The checker flywheels and is never reseeded from `d`.
  - On a match: `bad_cnt`←0.
  - On a mismatch: `err_pulse`=1 and `bad_cnt`+1. When `bad_cnt` reaches UNLOCK_ERRS, go to HUNT.
- Counters:
  - `word_count` increments on every `valid` in LOCKED.
  - `err_count` increments on every mismatch in LOCKED.
  - Both saturate at all-ones and never wrap.
  - `clr` zeroes both and takes priority over an increment in the same cycle. `clr` does not affect the FSM.
- Reset (`rst_n`=0 on any cycle, including mid-lock):
  - FSM goes to HUNT.
  - `pred`, `match_cnt`, `bad_cnt`, `locked`, `err_pulse`, `err_count` and `word_count` all reset to 0.

## Timing
- All outputs are registered.
- `err_pulse` is high in the cycle after the clock edge that samples the offending word.
- `locked` rises on the edge that samples the LOCK_CNT-th matching word, so it is visible in the following cycle. That is seed + LOCK_CNT words.
- `locked` falls on the edge that samples the UNLOCK_ERRS-th consecutive mismatch. The `err_pulse` for that word is asserted in the same cycle that `locked` falls.
- Counters update on the same edge as `err_pulse`/`locked`.
- Throughput is one word per cycle with no back-pressure. `valid` may be asserted continuously or with arbitrary gaps.

## Configuration
- Macro: `LFSR_CHECKER_STATS_EN`.
- Defined: `err_count` and `word_count` are implemented, together with `clr` handling.
- Undefined:
  - Both counters are removed and their outputs are tied to 0. `clr` is ignored.
  - `locked` and `err_pulse` behave identically to the defined build.

## Structure
- Shared package `lfsr_pkg` holds:
  - `LFSR_W` = 8 and `LFSR_SEED` = 8'h01.
  - Function `lfsr_next`, to be reused by the generator.
  - Enum `chk_state_t` with values HUNT, VERIFY, LOCKED.
- No sub-module. The single FSM, counters and predictor live in `lfsr_checker`.

## Test plan
All scenarios use default parameters.
- **Lock acquisition:** feed `valid`=1 with 01, 80, C0, 60, 30. `locked`=1 the cycle after 30 is sampled. `err_count`=0, and `word_count` stays 0 until the next word.
- **Single error:** once locked, send 98^01 = 99 in place of the expected 98, then continue with the correct sequence. Expected response: one `err_pulse`, `err_count`=1, `locked` stays 1, and the next correct word matches.
- **Lock loss:** once locked, send 3 consecutive wrong words. `err_count`=3, and `locked` falls together with the third `err_pulse`. A fresh correct stream relocks after 5 words.
- **Zero seed and gaps:**
  - In HUNT, send 00 repeatedly: the checker stays in HUNT.
  - Then send the lock sequence with `valid` low on alternate cycles: it locks after 5 valid words, with no false errors.
- **Reset mid-lock and clr:**
  - Assert `rst_n`=0 for 1 cycle while locked with nonzero counters: all outputs read 0 the next cycle and the state is HUNT.
  - Separately, pulse `clr` while locked with an error word arriving in the same cycle: `err_count`=0 and `locked` is unchanged.
- **Saturation:** with CNT_W=4, inject 20 errors, interleaved with correct words to keep lock. `err_count` holds at 15.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR width, seed, sequence function and checker state encoding
//
// Contents:
//   LFSR_W      - sequence word width (8)
//   LFSR_SEED   - generator reset seed (8'h01)
//   chk_state_t - checker FSM states HUNT / VERIFY / LOCKED
//   lfsr_next   - one step of the PRBS sequence, shared with the generator
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[7] ^ x[6] ^ x[5] ^ x[0], x[7:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising receive-side checker for the 8-bit PRBS
//
// Optional feature macro: LFSR_CHECKER_STATS_EN (statistics counters and clr).
//
// Parameters:
//   LOCK_CNT    - correct predictions after the seed word needed to lock (>=1)
//   UNLOCK_ERRS - consecutive mismatches while locked that drop lock (>=1)
//   CNT_W       - statistics counter width
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   valid      - d carries a sequence word this cycle
//   d          - received word
//   clr        - synchronous clear of the statistics counters
//   locked     - checker is in LOCKED
//   err_pulse  - one-cycle flag for a mismatching word while locked
//   err_count  - saturating count of mismatches while locked
//   word_count - saturating count of words checked while locked
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [LFSR_W-1:0] d,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int BC_W = $clog2(UNLOCK_ERRS + 1);

    chk_state_t        r_state;
    chk_state_t        w_state_nxt;
    logic [LFSR_W-1:0] r_pred;
    logic [LFSR_W-1:0] w_pred_nxt;
    logic [MC_W-1:0]   r_match_cnt;
    logic [MC_W-1:0]   w_match_nxt;
    logic [MC_W-1:0]   w_match_inc;
    logic [BC_W-1:0]   r_bad_cnt;
    logic [BC_W-1:0]   w_bad_nxt;
    logic [BC_W-1:0]   w_bad_inc;
    logic              r_locked;
    logic              r_err_pulse;
    logic              w_mismatch;
    logic              w_err_nxt;
    logic              w_word_inc;

    assign w_mismatch  = (d != r_pred);
    assign w_match_inc = r_match_cnt + MC_W'(1);
    assign w_bad_inc   = r_bad_cnt + BC_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_pred      <= '0;
            r_match_cnt <= '0;
            r_bad_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_cnt <= w_match_nxt;
            r_bad_cnt   <= w_bad_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match_cnt;
        w_bad_nxt   = r_bad_cnt;
        if (valid) begin
            case (r_state)
                HUNT: begin
                    // 8'h00 is the LFSR lock-up value and can never seed the predictor.
                    if (d != '0) begin
                        w_pred_nxt  = lfsr_next(d);
                        w_match_nxt = '0;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    w_pred_nxt = lfsr_next(d);
                    if (!w_mismatch) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == MC_W'(LOCK_CNT)) begin
                            w_state_nxt = LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end else begin
                        w_match_nxt = '0;
                        if (d == '0) begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on our own prediction; received data never reseeds here.
                    w_pred_nxt = lfsr_next(r_pred);
                    if (!w_mismatch) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_bad_nxt = w_bad_inc;
                        if (w_bad_inc == BC_W'(UNLOCK_ERRS)) begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        w_word_inc = valid && (r_state == LOCKED);
        w_err_nxt  = w_word_inc && w_mismatch;
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;

`ifdef LFSR_CHECKER_STATS_EN
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_word_count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            if (w_word_inc && !(&r_word_count)) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end
            if (w_err_nxt && !(&r_err_count)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign err_count  = r_err_count;
    assign word_count = r_word_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = clr ^ w_word_inc;
    assign err_count      = '0;
    assign word_count     = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker (default and CNT_W=4 instances)
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  d;
    logic        clr;
    logic        locked, err_pulse;
    logic [15:0] err_count, word_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4, word_count4;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .d(d), .clr(clr),
        .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .word_count(word_count)
    );

    lfsr_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .d(d), .clr(clr),
        .locked(locked4), .err_pulse(err_pulse4),
        .err_count(err_count4), .word_count(word_count4)
    );

    typedef struct {
        int   due;
        logic lk;
        logic er;
        int   ec;
        int   wc;
        int   ec4;
        int   wc4;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    int         ec = 0, wc = 0, ec4 = 0, wc4 = 0;
    logic       prev_lk = 1'b0;
    logic [7:0] s;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] nx(input logic [7:0] x);
        logic fb;
        fb = x[7] ^ x[6] ^ x[5] ^ x[0];
        return {fb, x[7:1]};
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("locked",       int'(locked),      int'(e.lk));
            chk("err_pulse",    int'(err_pulse),   int'(e.er));
            chk("err_count",    int'(err_count),   e.ec);
            chk("word_count",   int'(word_count),  e.wc);
            chk("locked_w4",    int'(locked4),     int'(e.lk));
            chk("err_pulse_w4", int'(err_pulse4),  int'(e.er));
            chk("err_count_w4", int'(err_count4),  e.ec4);
            chk("word_count_w4",int'(word_count4), e.wc4);
        end
    end

    // One cycle of stimulus; xl/xe are the hand-derived locked/err_pulse values after the edge.
    task automatic step(input logic v, input logic [7:0] dd, input logic cl,
                        input logic rs, input logic xl, input logic xe);
        exp_t e;
        valid = v; d = dd; clr = cl; rst_n = !rs;
        if (rs || cl) begin
            ec = 0; wc = 0; ec4 = 0; wc4 = 0;
        end else begin
            if (v && prev_lk) begin
                if (wc < 65535) wc++;
                if (wc4 < 15) wc4++;
            end
            if (xe) begin
                if (ec < 65535) ec++;
                if (ec4 < 15) ec4++;
            end
        end
        prev_lk = rs ? 1'b0 : xl;
        e.due = cyc + 1;
        e.lk  = xl;
        e.er  = xe;
        e.ec  = STATS ? ec  : 0;
        e.wc  = STATS ? wc  : 0;
        e.ec4 = STATS ? ec4 : 0;
        e.wc4 = STATS ? wc4 : 0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wrong, input logic xl, input logic xe);
        step(1'b1, wrong ? (s ^ 8'h01) : s, 1'b0, 1'b0, xl, xe);
        s = nx(s);
    endtask

    initial begin
        valid = 1'b0; d = 8'h00; clr = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);

        // Lock acquisition: 01 80 C0 60 30
        s = 8'h01;
        for (int i = 0; i < 5; i++) send(1'b0, i == 4, 1'b0);

        // Single error: 99 in place of 98
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);

        // Lock loss on third consecutive mismatch, then relock
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(1'b0, i == 4, 1'b0);
        step(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-lock with nonzero counters
        step(1'b1, s, 1'b0, 1'b1, 1'b0, 1'b0);
        s = nx(s);

        // Zero words never seed
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock sequence with valid low on alternate cycles
        s = 8'h01;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, i == 4, 1'b0);
            if (i < 4) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(1'b0, 1'b1, 1'b0);

        // clr together with an error word while locked
        step(1'b1, s ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        s = nx(s);
        send(1'b0, 1'b1, 1'b0);

        // Saturation: 20 errors interleaved with good words to hold lock
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b1, 1'b1);
            send(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
